id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DW, default 32: datapath width; instruction and register data.
REQ-002 Parameter RW, default 5: register address width.
REQ-003 Parameter CW, default 16: stall-counter width.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 id_valid  in  1  decode stage presents a valid instruction.
REQ-007 id_ready  out  1  stage accepts the decode-side instruction this cycle.
REQ-008 id_instr  in  DW  full decoded instruction; opcode is bits [31:26].
REQ-009 id_rs, id_rt  in  RW each  source register addresses.
REQ-010 id_dest  in  RW  destination register address.
REQ-011 id_rdata1, id_rdata2  in  DW each  register-file read data for rs and rt.
REQ-012 id_mem_load, id_mem_store, id_reg_write  in  1 each  decoded control bits.
REQ-013 ex_hold  in  1  downstream stage cannot advance; hold all EX outputs.
REQ-014 flush  in  1  branch/jump redirect; discard the EX-bound instruction.
REQ-015 ex_valid  out  1  EX outputs hold a real instruction.
REQ-016 ex_instr, ex_rdata1, ex_rdata2  out  DW each  registered copies feeding the forwarding unit.
REQ-017 ex_rs, ex_rt, ex_dest  out  RW each  registered register addresses.
REQ-018 ex_mem_load, ex_mem_store, ex_reg_write  out  1 each  registered control bits.
REQ-019 stall_count  out  CW  saturating count of load-use bubbles inserted.

Function
REQ-020 Stage SHALL be a single register slice: accepted decode inputs appear on ex_* exactly one cycle later.
REQ-021 FSM SHALL have states EMPTY, RUN, BUBBLE; reset enters EMPTY.
REQ-022 EMPTY -> RUN when id_valid and the instruction is accepted; RUN -> EMPTY when no instruction is accepted and ex_hold=0.
REQ-023 Load-use hazard SHALL be: ex_valid & ex_mem_load & id_valid & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
REQ-024 On hazard (ex_hold=0, flush=0): id_ready=0, next cycle ex_valid=0 with all ex_* fields zero (bubble), FSM -> BUBBLE, stall_count increments.
REQ-025 BUBBLE SHALL last exactly one cycle; next cycle the held decode instruction is accepted and FSM -> RUN.
REQ-026 id_ready SHALL be combinational: !ex_hold & !hazard; flush does not deassert id_ready.
REQ-027 ex_hold=1 SHALL freeze all ex_* outputs, FSM state, and stall_count; id_ready=0.
REQ-028 flush=1 SHALL load a bubble next cycle regardless of id_valid and hazard, FSM -> EMPTY, no stall_count increment.
REQ-029 Priority: reset > flush > ex_hold > hazard > normal accept.
REQ-030 Bubble SHALL be instruction 0x00000000 with dest 0 and all control bits 0, so downstream forwarding never matches a live register.
REQ-031 stall_count SHALL saturate at 2^CW-1 and never wrap.
REQ-032 id_valid=0 with no hold/flush SHALL load a bubble.

Reset
REQ-033 rst_n low SHALL immediately clear all ex_* outputs, ex_valid, and stall_count to 0 and force EMPTY, independent of clk.
REQ-034 Reset deassertion mid-hazard SHALL not produce a bubble or count; first post-reset cycle behaves as EMPTY.

Structure
REQ-035 Opcode field range, bubble encoding, and FSM state encoding SHALL live in shared package mips_pkg.
REQ-036 Hazard compare SHALL be a sub-module load_use_detect (purely combinational); registers and FSM stay in id_ex_stage.

Verification
REQ-037 Reset: drive rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 immediately, state EMPTY.
REQ-038 Pass-through: add $3,$1,$2 with rdata1=5, rdata2=7 -> next cycle ex_rs=1, ex_rt=2, ex_dest=3, ex_rdata1=5, ex_rdata2=7, ex_valid=1.
REQ-039 Load-use: lw $4 then add $5,$4,$1 -> id_ready=0 one cycle, one bubble, add appears cycle after, stall_count=1.
REQ-040 No-hazard load to $0: lw $0 then add $5,$0,$1 -> no bubble, stall_count=0.
REQ-041 Simultaneous flush and hazard -> bubble, EMPTY, stall_count unchanged; ex_hold for 3 cycles -> ex_* constant.
REQ-042 Saturation with CW=2: force 5 hazards -> stall_count stays 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode field location, bubble encoding,
// ID/EX FSM state encoding and the control-bit bundle carried down the pipe.
package mips_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [4:0]  BUBBLE_DEST  = 5'd0;

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_BUBBLE = 2'd2;

    typedef struct packed {
        logic mem_load;
        logic mem_store;
        logic reg_write;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '{mem_load: 1'b0, mem_store: 1'b0, reg_write: 1'b0};

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in EX and the
// one waiting in decode. Writes to $0 never create a dependency.
module load_use_detect #(
    parameter int RW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_mem_load,
    input  logic [RW-1:0] ex_dest,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          hazard
);

    logic dest_live;
    logic src_match;

    assign dest_live = (ex_dest != '0);
    assign src_match = (ex_dest == id_rs) || (ex_dest == id_rt);
    assign hazard    = ex_valid && ex_mem_load && id_valid && dest_live && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register slice with load-use bubble insertion, downstream
// hold, redirect flush and a saturating count of inserted load-use bubbles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [DW-1:0] id_instr,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_dest,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic          id_mem_load,
    input  logic          id_mem_store,
    input  logic          id_reg_write,
    input  logic          ex_hold,
    input  logic          flush,
    output logic          ex_valid,
    output logic [DW-1:0] ex_instr,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_dest,
    output logic          ex_mem_load,
    output logic          ex_mem_store,
    output logic          ex_reg_write,
    output logic [CW-1:0] stall_count
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    logic          valid_q,  valid_d;
    logic [DW-1:0] instr_q,  instr_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [DW-1:0] rdata2_q, rdata2_d;
    logic [RW-1:0] rs_q,     rs_d;
    logic [RW-1:0] rt_q,     rt_d;
    logic [RW-1:0] dest_q,   dest_d;
    ctrl_t         ctrl_q,   ctrl_d;
    logic [CW-1:0] stall_q,  stall_d;
    logic [1:0]    state_q,  state_d;
    logic          hazard;
    logic          load_bubble;
    logic          load_id;

    load_use_detect #(.RW(RW)) u_detect (
        .ex_valid    (valid_q),
        .ex_mem_load (ctrl_q.mem_load),
        .ex_dest     (dest_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard)
    );

    assign id_ready = !ex_hold && !hazard;

    // Priority: flush > hold > hazard > accept; idle decode also loads a bubble.
    always_comb begin
        load_bubble = 1'b0;
        load_id     = 1'b0;
        state_d     = state_q;
        stall_d     = stall_q;
        if (flush) begin
            load_bubble = 1'b1;
            state_d     = ST_EMPTY;
        end else if (!ex_hold) begin
            if (hazard) begin
                load_bubble = 1'b1;
                state_d     = ST_BUBBLE;
                stall_d     = sat_inc(stall_q);
            end else if (id_valid) begin
                load_id = 1'b1;
                state_d = ST_RUN;
            end else begin
                load_bubble = 1'b1;
                state_d     = ST_EMPTY;
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        instr_d  = instr_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        dest_d   = dest_q;
        ctrl_d   = ctrl_q;
        if (load_bubble) begin
            valid_d  = 1'b0;
            instr_d  = DW'(BUBBLE_INSTR);
            rdata1_d = '0;
            rdata2_d = '0;
            rs_d     = '0;
            rt_d     = '0;
            dest_d   = RW'(BUBBLE_DEST);
            ctrl_d   = BUBBLE_CTRL;
        end else if (load_id) begin
            valid_d  = 1'b1;
            instr_d  = id_instr;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            rs_d     = id_rs;
            rt_d     = id_rt;
            dest_d   = id_dest;
            ctrl_d   = '{mem_load: id_mem_load, mem_store: id_mem_store, reg_write: id_reg_write};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            dest_q   <= '0;
            ctrl_q   <= BUBBLE_CTRL;
            stall_q  <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            dest_q   <= dest_d;
            ctrl_q   <= ctrl_d;
            stall_q  <= stall_d;
            state_q  <= state_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_instr     = instr_q;
    assign ex_rdata1    = rdata1_q;
    assign ex_rdata2    = rdata2_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_dest      = dest_q;
    assign ex_mem_load  = ctrl_q.mem_load;
    assign ex_mem_store = ctrl_q.mem_store;
    assign ex_reg_write = ctrl_q.reg_write;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (stall counter narrowed to 2 bits so
// saturation is reachable in a few hazards).
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 2;

    localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] LW_4      = 32'h8C24_0000; // lw  $4,0($1)
    localparam logic [31:0] ADD_5_4_1 = 32'h0081_2820; // add $5,$4,$1
    localparam logic [31:0] LW_0      = 32'h8C20_0000; // lw  $0,0($1)
    localparam logic [31:0] ADD_5_0_1 = 32'h0001_2820; // add $5,$0,$1

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_ready;
    logic [DW-1:0] id_instr, id_rdata1, id_rdata2;
    logic [RW-1:0] id_rs, id_rt, id_dest;
    logic          id_mem_load, id_mem_store, id_reg_write;
    logic          ex_hold, flush;
    logic          ex_valid;
    logic [DW-1:0] ex_instr, ex_rdata1, ex_rdata2;
    logic [RW-1:0] ex_rs, ex_rt, ex_dest;
    logic          ex_mem_load, ex_mem_store, ex_reg_write;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_rdata1    (id_rdata1),
        .id_rdata2    (id_rdata2),
        .id_mem_load  (id_mem_load),
        .id_mem_store (id_mem_store),
        .id_reg_write (id_reg_write),
        .ex_hold      (ex_hold),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_instr     (ex_instr),
        .ex_rdata1    (ex_rdata1),
        .ex_rdata2    (ex_rdata2),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dest      (ex_dest),
        .ex_mem_load  (ex_mem_load),
        .ex_mem_store (ex_mem_store),
        .ex_reg_write (ex_reg_write),
        .stall_count  (stall_count)
    );

    task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dst, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ld, input logic st, input logic wr);
        id_valid = v; id_instr = ins; id_rs = rs; id_rt = rt; id_dest = dst;
        id_rdata1 = r1; id_rdata2 = r2;
        id_mem_load = ld; id_mem_store = st; id_reg_write = wr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
        idle();
        step();
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", ex_valid); end
        checks++; if (stall_count !== 2'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_count); end
        rst_n = 1'b1;
        step();
        // load something so the async reset below has live state to clear
        drive(1'b1, ADD_3_1_2, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b exp 1", ex_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b exp 0", ex_valid); end
        checks++; if (ex_instr !== 32'h0) begin errors++; $display("FAIL rst_async_instr got %h exp 0", ex_instr); end
        checks++; if ({ex_rs, ex_rt, ex_dest} !== 15'h0) begin errors++; $display("FAIL rst_async_regs got %h exp 0", {ex_rs, ex_rt, ex_dest}); end
        checks++; if ({ex_rdata1, ex_rdata2} !== 64'h0) begin errors++; $display("FAIL rst_async_data got %h exp 0", {ex_rdata1, ex_rdata2}); end
        checks++; if ({ex_mem_load, ex_mem_store, ex_reg_write} !== 3'b000) begin errors++; $display("FAIL rst_async_ctrl got %b exp 000", {ex_mem_load, ex_mem_store, ex_reg_write}); end
        checks++; if (dut.state_q !== ST_EMPTY) begin errors++; $display("FAIL rst_async_state got %0d exp %0d", dut.state_q, ST_EMPTY); end
        idle();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_pass_through();
        drive(1'b1, ADD_3_1_2, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL pt_ready got %0b exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pt_valid got %0b exp 1", ex_valid); end
        checks++; if (ex_instr !== ADD_3_1_2) begin errors++; $display("FAIL pt_instr got %h exp %h", ex_instr, ADD_3_1_2); end
        checks++; if ({ex_rs, ex_rt, ex_dest} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL pt_regs got %0d %0d %0d exp 1 2 3", ex_rs, ex_rt, ex_dest); end
        checks++; if (ex_rdata1 !== 32'd5 || ex_rdata2 !== 32'd7) begin errors++; $display("FAIL pt_data got %0d %0d exp 5 7", ex_rdata1, ex_rdata2); end
        checks++; if ({ex_mem_load, ex_mem_store, ex_reg_write} !== 3'b001) begin errors++; $display("FAIL pt_ctrl got %b exp 001", {ex_mem_load, ex_mem_store, ex_reg_write}); end
        checks++; if (dut.state_q !== ST_RUN) begin errors++; $display("FAIL pt_state got %0d exp %0d", dut.state_q, ST_RUN); end
        idle();
        step();
        checks++; if (ex_valid !== 1'b0 || ex_instr !== 32'h0 || ex_dest !== 5'd0) begin errors++; $display("FAIL pt_idle got v%0b i%h d%0d exp v0 i0 d0", ex_valid, ex_instr, ex_dest); end
        checks++; if (dut.state_q !== ST_EMPTY) begin errors++; $display("FAIL pt_idle_state got %0d exp %0d", dut.state_q, ST_EMPTY); end
    endtask

    task automatic test_load_use();
        pulse_reset();
        drive(1'b1, LW_4, 5'd1, 5'd4, 5'd4, 32'd100, 32'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, ADD_5_4_1, 5'd4, 5'd1, 5'd5, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_low got %0b exp 0", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_instr !== 32'h0 || ex_dest !== 5'd0 || ex_reg_write !== 1'b0 || ex_mem_load !== 1'b0) begin errors++; $display("FAIL lu_bubble got v%0b i%h d%0d exp all 0", ex_valid, ex_instr, ex_dest); end
        checks++; if (stall_count !== 2'd1) begin errors++; $display("FAIL lu_stall got %0d exp 1", stall_count); end
        checks++; if (dut.state_q !== ST_BUBBLE) begin errors++; $display("FAIL lu_state got %0d exp %0d", dut.state_q, ST_BUBBLE); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_high got %0b exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_instr !== ADD_5_4_1 || ex_dest !== 5'd5) begin errors++; $display("FAIL lu_add got v%0b i%h d%0d exp v1 i%h d5", ex_valid, ex_instr, ex_dest, ADD_5_4_1); end
        checks++; if (dut.state_q !== ST_RUN || stall_count !== 2'd1) begin errors++; $display("FAIL lu_after got st%0d cnt%0d exp st%0d cnt1", dut.state_q, stall_count, ST_RUN); end
        idle();
        step();
    endtask

    task automatic test_load_r0();
        pulse_reset();
        drive(1'b1, LW_0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, ADD_5_0_1, 5'd0, 5'd1, 5'd5, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_instr !== ADD_5_0_1) begin errors++; $display("FAIL r0_add got v%0b i%h exp v1 i%h", ex_valid, ex_instr, ADD_5_0_1); end
        checks++; if (stall_count !== 2'd0) begin errors++; $display("FAIL r0_stall got %0d exp 0", stall_count); end
        idle();
        step();
    endtask

    task automatic test_flush_hold();
        logic [CW-1:0] cnt0;
        pulse_reset();
        drive(1'b1, LW_4, 5'd1, 5'd4, 5'd4, 32'd100, 32'd0, 1'b1, 1'b0, 1'b1);
        step();
        cnt0 = stall_count;
        drive(1'b1, ADD_5_4_1, 5'd4, 5'd1, 5'd5, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_instr !== 32'h0) begin errors++; $display("FAIL fl_bubble got v%0b i%h exp v0 i0", ex_valid, ex_instr); end
        checks++; if (dut.state_q !== ST_EMPTY) begin errors++; $display("FAIL fl_state got %0d exp %0d", dut.state_q, ST_EMPTY); end
        checks++; if (stall_count !== cnt0) begin errors++; $display("FAIL fl_stall got %0d exp %0d", stall_count, cnt0); end
        // flush alone keeps decode ready
        idle();
        drive(1'b1, ADD_3_1_2, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %0b exp 1", id_ready); end
        flush = 1'b0;
        step();
        ex_hold = 1'b1;
        drive(1'b1, LW_0, 5'd9, 5'd8, 5'd7, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %0b exp 0", id_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ex_valid !== 1'b1 || ex_instr !== ADD_3_1_2 || ex_dest !== 5'd3 || ex_rdata1 !== 32'd5 || ex_rdata2 !== 32'd7 || dut.state_q !== ST_RUN) begin
                errors++; $display("FAIL hold_cycle%0d got v%0b i%h d%0d r1 %0d st%0d exp v1 i%h d3 r1 5 st%0d", i, ex_valid, ex_instr, ex_dest, ex_rdata1, dut.state_q, ADD_3_1_2, ST_RUN);
            end
        end
        ex_hold = 1'b0;
        step();
        checks++; if (ex_instr !== LW_0 || ex_rdata1 !== 32'hDEAD) begin errors++; $display("FAIL hold_release got i%h r1 %h exp i%h r1 dead", ex_instr, ex_rdata1, LW_0); end
        idle();
        step();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_cnt;
        pulse_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, LW_4, 5'd1, 5'd4, 5'd4, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
            step();
            drive(1'b1, ADD_5_4_1, 5'd4, 5'd1, 5'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            step();
            exp_cnt = (i > 3) ? 2'd3 : 2'(i);
            checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL sat_hazard%0d got %0d exp %0d", i, stall_count, exp_cnt); end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_load_r0();
        test_flush_hold();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
